parallel_to_serial_tx: RTL and testbench
========================================

// Module: parallel_to_serial_tx
//
// PURPOSE
//   Transmit side of the valid-only serial bit link: takes width-bit words over
//   a valid/ready handshake and emits them one bit per clock, LSB first.
//   serial_valid is high for every bit of a word. serial_last marks the final bit.
//   A one-word holding register lets consecutive words stream with no idle cycle.
//   Sits between a word-producing block and a serial-to-parallel receiver.
//
// PARAMETERS
//   width   8   bits per word; legal range width >= 2
//
// PORTS
//   clk             input   1       single clock, all logic on posedge
//   rst             input   1       synchronous reset, active-high
//   parallel_valid  input   1       parallel_data is offered this cycle
//   parallel_data   input   width   word to transmit
//   parallel_ready  output  1       word is accepted when parallel_valid & parallel_ready
//   serial_valid    output  1       serial_data carries a valid bit
//   serial_data     output  1       current bit, LSB of the word first
//   serial_last     output  1       high with bit width-1 of each word
//
// BEHAVIOUR
//   Reset and idle
//   - Reset: while rst=1 at a posedge, the shifter, holding register and bit counter clear.
//     Next cycle: serial_valid=0, serial_data=0, serial_last=0.
//   - parallel_ready is forced to 0 while rst=1.
//   - Reset mid-word drops the partial word and any held word; nothing resumes after reset.
//   - When serial_valid=0, serial_data=0 and serial_last=0.
//
//   Storage
//   - Shifter: shift register, bit counter cnt (0..width-1), and flag busy.
//   - Holding register: hold_data and hold_valid.
//   - parallel_ready = !rst & !hold_valid. It depends only on state, never on
//     parallel_valid.
//
//   Accepted word at a posedge
//   - The word loads straight into the shifter if the shifter is idle, or if it is sending
//     its last bit this cycle (cnt==width-1). Otherwise the word goes to the holding register.
//
//   Shifter, per cycle while busy
//   - Outputs: serial_valid=1, serial_data=shift[0], serial_last=(cnt==width-1).
//   - At the posedge: shift right, cnt++.
//   - When cnt==width-1, the next word loads at that posedge. The holding register has
//     priority over a same-cycle new word. If no word is available, busy clears.
//
//   Timing
//   - Latency: a word accepted at edge N, with the shifter free, drives bit0 in cycle N+1.
//   - The word occupies exactly width consecutive serial_valid cycles.
//   - Back-to-back words produce no gap.
//
//   Simultaneous events
//   - Holding register full while the shifter sends its last bit: the held word moves to the
//     shifter and hold_valid clears. parallel_ready rises in the next cycle.
//   - A new word offered in that same cycle is not accepted, because parallel_ready was 0.
//
//   Counter and ordering
//   - cnt is $clog2(width) bits wide and wraps width-1 -> 0 on each word boundary.
//   - No word is ever dropped, duplicated or reordered.
//
// TESTING (width=8)
//   1 Single word: accept 8'hA5 at edge N, then stay idle.
//     -> Cycles N+1..N+8 give serial_data 1,0,1,0,0,1,0,1 with serial_valid=1.
//     -> serial_last=1 only in cycle N+8. serial_valid=0 from N+9.
//   2 Streaming: hold parallel_valid=1 with 8'h01, 8'h80, 8'hFF.
//     -> 24 contiguous serial_valid cycles with the words in order.
//     -> serial_last pulses in cycles 8, 16 and 24.
//     -> parallel_ready is low whenever the holding register is full.
//   3 Backpressure: offer 8'h3C while parallel_ready=0 and keep it stable.
//     -> The word is accepted exactly once, when ready rises, and is transmitted intact after
//        the current word.
//   4 Reset mid-word: assert rst for 1 cycle after 3 bits of 8'hF0 have been sent.
//     -> serial_valid=0 the next cycle and the held word is lost.
//     -> A new word 8'h5A then sends all 8 bits from bit0.
//   5 Loopback: drive a serial-to-parallel receiver model from serial_valid/serial_data
//     with 1000 random words and random parallel_valid gaps.
//     -> The received words equal the sent words, in order.
//   6 Idle: parallel_valid=0 for 20 cycles.
//     -> serial_valid, serial_data and serial_last stay 0; parallel_ready stays 1.

Source files
------------

// File: rtl/parallel_to_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : parallel_to_serial_tx
// Description : Word-to-bit serializer for the valid-only serial bit link.
//               Accepts WIDTH-bit words over valid/ready and emits them one
//               bit per clock, LSB first, with a one-word holding register so
//               consecutive words stream without an idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module parallel_to_serial_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    input  logic [WIDTH-1:0] parallel_data,
    output logic             parallel_ready,
    output logic             serial_valid,
    output logic             serial_data,
    output logic             serial_last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_cnt_zero = '0;
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_hold_data;
    logic             r_hold_valid;

    logic             w_accept;
    logic             w_last_bit;

    // Ready is a pure function of state (and reset), never of parallel_valid.
    assign parallel_ready = !rst && !r_hold_valid;
    assign w_accept       = parallel_valid && parallel_ready;
    assign w_last_bit     = r_busy && (r_cnt == c_cnt_last);

    // Serial outputs are forced to zero whenever no bit is being sent.
    assign serial_valid = r_busy;
    assign serial_data  = r_busy && r_shift[0];
    assign serial_last  = w_last_bit;

    // Shifter and holding register; on the last bit the held word wins over a
    // fresh word (a fresh word cannot be accepted then anyway, ready is low).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_cnt        <= c_cnt_zero;
            r_busy       <= 1'b0;
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_last_bit) begin
            r_cnt <= c_cnt_zero;
            if (r_hold_valid) begin
                r_shift      <= r_hold_data;
                r_hold_valid <= 1'b0;
            end else if (w_accept) begin
                r_shift <= parallel_data;
            end else begin
                r_shift <= '0;
                r_busy  <= 1'b0;
            end
        end else if (r_busy) begin
            r_shift <= {1'b0, r_shift[WIDTH-1:1]};
            r_cnt   <= r_cnt + c_cnt_one;
            if (w_accept) begin
                r_hold_data  <= parallel_data;
                r_hold_valid <= 1'b1;
            end
        end else if (w_accept) begin
            r_shift <= parallel_data;
            r_cnt   <= c_cnt_zero;
            r_busy  <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parallel_to_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_parallel_to_serial_tx
// Description : Randomized self-checking bench for parallel_to_serial_tx.
//               Reference model is a queue of pending bits: every accepted
//               word appends WIDTH bits, every transmitting cycle pops one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parallel_to_serial_tx;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             parallel_valid;
    logic [WIDTH-1:0] parallel_data;
    logic             parallel_ready;
    logic             serial_valid;
    logic             serial_data;
    logic             serial_last;

    parallel_to_serial_tx #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .parallel_valid (parallel_valid),
        .parallel_data  (parallel_data),
        .parallel_ready (parallel_ready),
        .serial_valid   (serial_valid),
        .serial_data    (serial_data),
        .serial_last    (serial_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: pending bits {last, bit}, words still to be received
    logic [1:0]       bq[$];
    logic [WIDTH-1:0] sentq[$];
    logic [WIDTH-1:0] rx_word;
    int               rx_n;
    logic             accepted;

    int n_cmp;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: check ready, apply the edge to the model, check serial outputs.
    task automatic step();
        logic exp_ready;
        logic [1:0] e;
        #1;
        exp_ready = !rst && (bq.size() <= WIDTH);
        chk("parallel_ready", {31'd0, parallel_ready}, {31'd0, exp_ready});
        accepted = parallel_valid && exp_ready;
        @(posedge clk);
        if (rst) begin
            bq.delete();
            sentq.delete();
            rx_n    = 0;
            rx_word = '0;
        end else begin
            if (bq.size() > 0) void'(bq.pop_front());
            if (accepted) begin
                for (int i = 0; i < WIDTH; i++)
                    bq.push_back({(i == WIDTH - 1), parallel_data[i]});
                sentq.push_back(parallel_data);
            end
        end
        @(negedge clk);
        if (bq.size() > 0) e = bq[0];
        else               e = 2'b00;
        chk("serial_valid", {31'd0, serial_valid}, {31'd0, (bq.size() > 0)});
        chk("serial_data",  {31'd0, serial_data},  {31'd0, e[0]});
        chk("serial_last",  {31'd0, serial_last},  {31'd0, e[1]});
        // Loopback receiver built from the DUT's serial outputs
        if (serial_valid) begin
            rx_word = {serial_data, rx_word[WIDTH-1:1]};
            rx_n++;
            if (serial_last) begin
                chk("rx_bitcount", rx_n, WIDTH);
                if (sentq.size() > 0) chk("rx_word", {24'd0, rx_word}, {24'd0, sentq.pop_front()});
                else chk("rx_word_unexpected", {24'd0, rx_word}, 32'hFFFF_FFFF);
                rx_n = 0;
            end
        end
    endtask

    // Offer a word and keep it stable until accepted; valid is left high.
    task automatic send_word(input logic [WIDTH-1:0] d);
        int budget;
        parallel_valid = 1'b1;
        parallel_data  = d;
        budget = 0;
        do begin
            step();
            budget++;
        end while (!accepted && budget < 100);
        chk("accept_timeout", {31'd0, accepted}, 32'd1);
    endtask

    task automatic idle(input int n);
        parallel_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rx_n = 0;
        rx_word = '0;
        accepted = 1'b0;
        rst = 1'b1;
        parallel_valid = 1'b0;
        parallel_data = '0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // Idle: outputs stay low, ready stays high
        idle(20);

        // Single word
        send_word(8'hA5);
        idle(12);

        // Streaming three words with valid held high
        send_word(8'h01);
        send_word(8'h80);
        send_word(8'hFF);
        idle(30);

        // Backpressure: 3C offered while the holding register is full
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h3C);
        idle(30);

        // Reset mid-word: F0 in flight, 77 held, reset after 3 bits
        send_word(8'hF0);
        send_word(8'h77);
        parallel_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("post_reset_empty", {31'd0, serial_valid}, 32'd0);
        idle(3);
        send_word(8'h5A);
        idle(12);

        // Random loopback with random gaps
        for (int w = 0; w < 1000; w++) begin
            send_word(WIDTH'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                parallel_valid = 1'b0;
                parallel_data  = WIDTH'($urandom);
                for (int g = 0; g < int'($urandom_range(1, 12)); g++) step();
            end
        end
        idle(40);

        chk("all_words_received", sentq.size(), 0);
        chk("bit_queue_drained", bq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
